// File: rtl/mem_arbiter_if.sv
// Memory handshake bundle: read/write levels, address/data/strobe, addr_ready qualifier, one-cycle data_ready.
// master drives a request and receives the completion; slave accepts the request and returns the completion.
interface mem_arbiter_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        addr_ready;
  logic [31:0] rdata;
  logic        data_ready;
  logic        err;

  modport master (
    output read, write, addr, wdata, wstrb, addr_ready,
    input  rdata, data_ready
  );

  modport slave (
    input  read, write, addr, wdata, wstrb, addr_ready,
    output rdata, data_ready, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises CPU (m0) and secondary master (m1) onto one memory port, one access at a time.
// Request at edge t drives mem pins in cycle t+1; optional watchdog completion with error under MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int          ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master mem,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;

  logic        req0, req1;
  logic        own_req, own_rd, own_wr;
  logic [31:0] own_addr, own_wdata;
  logic [3:0]  own_wstrb;
  logic        expire;
  logic        done, done_err;

  assign req0 = m0.addr_ready & (m0.read | m0.write);
  assign req1 = m1.addr_ready & (m1.read | m1.write);

  // Only the registered owner selects between ports, so no mN input reaches mM outputs.
  always_comb begin
    own_req   = owner_q ? req1        : req0;
    own_rd    = owner_q ? m1.read     : m0.read;
    own_wr    = owner_q ? m1.write    : m0.write;
    own_addr  = owner_q ? m1.addr     : m0.addr;
    own_wdata = owner_q ? m1.wdata    : m0.wdata;
    own_wstrb = owner_q ? m1.wstrb    : m0.wstrb;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds (BUSY cycle number - 1), so expiry lands on the TIMEOUT_CYCLES-th BUSY cycle.
  assign cnt_d  = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
  assign expire = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_last_d      = rr_last_q;
    grant          = 2'b00;
    busy           = 1'b0;
    done           = 1'b0;
    done_err       = 1'b0;
    mem.read       = 1'b0;
    mem.write      = 1'b0;
    mem.addr       = '0;
    mem.wdata      = '0;
    mem.wstrb      = '0;
    mem.addr_ready = 1'b0;

    if (state_q == IDLE) begin
      if (req0 || req1) begin
        state_d = BUSY;
        if (req0 && req1) begin
          owner_d = (ROUND_ROBIN != 0) ? ~rr_last_q : 1'b0;
        end else begin
          owner_d = req1;
        end
      end
    end else begin
      busy  = 1'b1;
      grant = owner_q ? 2'b10 : 2'b01;
      if (!own_req) begin
        state_d = IDLE;
      end else begin
        if (mem.data_ready || !expire) begin
          // A read+write request is treated as a read.
          mem.read       = own_rd;
          mem.write      = own_wr & ~own_rd;
          mem.addr       = own_addr;
          mem.wdata      = own_wdata;
          mem.wstrb      = own_wstrb;
          mem.addr_ready = 1'b1;
        end
        if (mem.data_ready || expire) begin
          done      = 1'b1;
          done_err  = ~mem.data_ready;
          state_d   = IDLE;
          rr_last_d = owner_q;
        end
      end
    end
  end

  assign m0.data_ready = done & ~owner_q;
  assign m0.err        = done_err & ~owner_q;
  assign m0.rdata      = (done & ~done_err & ~owner_q) ? mem.rdata : '0;
  assign m1.data_ready = done & owner_q;
  assign m1.err        = done_err & owner_q;
  assign m1.rdata      = (done & ~done_err & owner_q) ? mem.rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single memory port between the CPU core (port 0) and a secondary master such as DMA or debug (port 1).
- Both sides use the core's memory handshake:
  - read/write level, address/data/strobe, and an addr_ready qualifier;
  - the memory answers with a one-cycle data_ready pulse.
- Sits between the core's mem_* pins and the memory/peripheral fabric. Serialises transactions: one outstanding access at a time.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = fixed priority, port 0 wins.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_read, m0_write  in  1 each  port 0 access type, held until completion
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_wstrb  in  4  port 0 byte strobes
- m0_addr_ready  in  1  port 0 request valid
- m0_rdata  out  32  read data to port 0
- m0_data_ready  out  1  completion pulse to port 0
- m0_err  out  1  port 0 timeout completion
- m1_read, m1_write, m1_addr, m1_wdata, m1_wstrb, m1_addr_ready, m1_rdata, m1_data_ready, m1_err: as port 0, for port 1
- mem_read, mem_write  out  1 each  to memory
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_wstrb  out  4  to memory
- mem_addr_ready  out  1  to memory
- mem_rdata  in  32  from memory
- mem_data_ready  in  1  from memory
- grant  out  2  one-hot owner; 00 when idle
- busy  out  1  transaction in progress

Behaviour:
- Request definition: reqN = mN_addr_ready & (mN_read | mN_write). Read and write both set is illegal; treat it as a read.
- States: IDLE, BUSY. Registers: state, owner (1 bit), rr_last (1 bit).
- Reset (async, immediate): state = IDLE, rr_last = 1 (port 0 wins the first tie).
  - All outputs 0, except mN_rdata and mem_addr/wdata/wstrb, which are 0 while idle.
- IDLE:
  - mem_* outputs all 0; grant = 00; busy = 0.
  - Any reqN at a clock edge -> BUSY with owner = winner.
  - Contention with ROUND_ROBIN = 1: the winner is the port that is not rr_last. With ROUND_ROBIN = 0: port 0 wins.
- BUSY:
  - mem_read/write/addr/wdata/wstrb/addr_ready are combinationally muxed from the owner port.
  - grant is one-hot of owner; busy = 1.
- Latency: a request sampled in IDLE at edge t reaches the mem pins during cycle t+1. Minimum 2 cycles from request to earliest data_ready.
- Completion:
  - mem_data_ready = 1 in BUSY -> m[owner]_data_ready = 1 combinationally in the same cycle, m[owner]_rdata = mem_rdata.
  - At that edge: state -> IDLE, rr_last = owner.
  - One idle cycle always separates back-to-back transactions.
- Non-owner port: data_ready = 0, err = 0, rdata = 0.
- mem_data_ready while IDLE: ignored.
- Abort: owner drops mN_addr_ready before completion -> mem_* deasserted in that cycle, state -> IDLE at the next edge. No data_ready is issued and rr_last is unchanged.
- The arbiter is free of combinational paths from mN inputs to mM outputs for M != N.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-minimum counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no mem_data_ready: m[owner]_data_ready = 1, m[owner]_err = 1, rdata = 0, mem_* forced to 0 in that cycle, then state -> IDLE and rr_last = owner.
  - mem_data_ready in the same cycle as expiry takes precedence: normal completion, err = 0.
- Without the macro: no counter is built, mN_err is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Single read on port 0: m0_addr = 0x100, memory returns 0xDEADBEEF after 3 cycles -> m0_rdata = 0xDEADBEEF with a 1-cycle m0_data_ready; grant 01 then 00; m1 outputs remain 0.
- Simultaneous requests, ROUND_ROBIN = 1, both held across 4 transactions -> grant order 01, 10, 01, 10, with one idle cycle between each.
- Simultaneous requests, ROUND_ROBIN = 0 -> port 0 wins every time while it keeps requesting. Port 1 is served only when port 0 is idle.
- Port 1 write: addr 0x203, wstrb 0x8, wdata 0xAB000000 -> mem_wstrb = 0x8 and mem_wdata = 0xAB000000 while BUSY; completion goes to m1 only.
- rst asserted mid-BUSY, between clock edges -> all outputs 0 immediately. After release, a pending port 1 request is granted first when port 0 is idle.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, memory never responds -> m0_data_ready = m0_err = 1 on the 8th BUSY cycle with rdata = 0, then IDLE. Without the macro, busy stays 1 for 100+ cycles.
